// File: rtl/pifo_sched_pkg.sv
// Shared widths, calendar element layout and rank arithmetic helpers for the
// root PIFO scheduler front end.
package pifo_sched_pkg;

  localparam int CAL_SIZE          = 1024;
  localparam int CAL_CNT_WIDTH     = 11;
  localparam int BUFFER_ADDR_WIDTH = 12;
  localparam int RANK_WIDTH        = 19;
  localparam int INFO_WIDTH        = 32;
  localparam int NUM_FLOWS         = 16;
  localparam int FLOW_ID_WIDTH     = 4;
  localparam int LEN_WIDTH         = 16;
  localparam int SHIFT_WIDTH       = 4;

  localparam int INFO_VALID_BIT = 31;
  localparam int INFO_RANK_MSB  = 30;
  localparam int INFO_RANK_LSB  = 12;
  localparam int INFO_ADDR_MSB  = 11;

  typedef logic [RANK_WIDTH-1:0]        rank_t;
  typedef logic [BUFFER_ADDR_WIDTH-1:0] addr_t;
  typedef logic [INFO_WIDTH-1:0]        info_t;

  localparam rank_t RANK_MAX = '1;

  function automatic info_t pack_info(input rank_t rank, input addr_t addr);
    return {1'b1, rank, addr};
  endfunction

  // Ranks never wrap: a wrapped finish time would jump ahead of every queued flow.
  function automatic rank_t sat_add(input rank_t a, input logic [LEN_WIDTH-1:0] b);
    logic [RANK_WIDTH:0] sum;
    sum = {1'b0, a} + {{(RANK_WIDTH + 1 - LEN_WIDTH){1'b0}}, b};
    return sum[RANK_WIDTH] ? RANK_MAX : sum[RANK_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/stfq_flow_table.sv
// Per-flow STFQ state: last finish time and weight shift, with one combinational
// read port, one finish write port and an independent config port for shifts.
module stfq_flow_table
  import pifo_sched_pkg::*;
(
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [FLOW_ID_WIDTH-1:0] rd_flow,
  output logic [RANK_WIDTH-1:0]    rd_finish,
  output logic [SHIFT_WIDTH-1:0]   rd_shift,
  input  logic                     wr_en,
  input  logic [FLOW_ID_WIDTH-1:0] wr_flow,
  input  logic [RANK_WIDTH-1:0]    wr_finish,
  input  logic                     cfg_wr_valid,
  input  logic [FLOW_ID_WIDTH-1:0] cfg_wr_flow,
  input  logic [SHIFT_WIDTH-1:0]   cfg_wr_shift
);

  logic [RANK_WIDTH-1:0]  finish_q [NUM_FLOWS];
  logic [SHIFT_WIDTH-1:0] shift_q  [NUM_FLOWS];

  assign rd_finish = finish_q[rd_flow];
  assign rd_shift  = shift_q[rd_flow];

  // A shift written this cycle is seen by readers from the next cycle onward.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_FLOWS; i++) begin
        finish_q[i] <= '0;
        shift_q[i]  <= '0;
      end
    end else begin
      if (wr_en)        finish_q[wr_flow]    <= wr_finish;
      if (cfg_wr_valid) shift_q[cfg_wr_flow] <= cfg_wr_shift;
    end
  end

endmodule

// File: rtl/pifo_stfq_enqueue_ctrl.sv
// Root PIFO calendar front end: ranks descriptors with start-time fair queueing,
// issues calendar inserts/pops, tracks occupancy and returns dequeued addresses.
module pifo_stfq_enqueue_ctrl
  import pifo_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        s_desc_valid,
  output logic        s_desc_ready,
  input  logic [11:0] s_desc_buf_addr,
  input  logic [3:0]  s_desc_flow_id,
  input  logic [15:0] s_desc_len,
  input  logic        cfg_wr_valid,
  input  logic [3:0]  cfg_wr_flow,
  input  logic [3:0]  cfg_wr_shift,
  input  logic        deq_req,
  output logic        deq_ack,
  output logic [11:0] deq_buf_addr,
  output logic        deq_empty,
  output logic [31:0] m_pifo_info,
  output logic        m_pifo_insert_en,
  output logic        m_pifo_pop_en,
  input  logic [31:0] s_pifo_top
);

  logic [CAL_CNT_WIDTH-1:0] occ_q;
  logic [RANK_WIDTH-1:0]    vtime_q;
  logic [RANK_WIDTH-1:0]    rd_finish;
  logic [SHIFT_WIDTH-1:0]   rd_shift;
  logic [RANK_WIDTH-1:0]    start_rank;
  logic [RANK_WIDTH-1:0]    new_finish;
  logic [LEN_WIDTH-1:0]     cost;
  logic [RANK_WIDTH-1:0]    top_rank;
  logic                     pop_grant;
  logic                     accept;

  // s_desc handshake: a descriptor transfers on any cycle where s_desc_valid and
  // s_desc_ready are both high; ready drops in the same cycle a pop is granted
  // or when the calendar (including the insert in flight) is full, and the
  // source must hold valid and payload stable until the transfer happens.
  assign pop_grant    = deq_req && (occ_q != '0);
  assign s_desc_ready = rstn && !pop_grant && (occ_q < CAL_CNT_WIDTH'(CAL_SIZE));
  assign accept       = s_desc_valid && s_desc_ready;
  assign deq_empty    = (occ_q == '0);

  stfq_flow_table u_flow_table (
    .clk          (clk),
    .rstn         (rstn),
    .rd_flow      (s_desc_flow_id),
    .rd_finish    (rd_finish),
    .rd_shift     (rd_shift),
    .wr_en        (accept),
    .wr_flow      (s_desc_flow_id),
    .wr_finish    (new_finish),
    .cfg_wr_valid (cfg_wr_valid),
    .cfg_wr_flow  (cfg_wr_flow),
    .cfg_wr_shift (cfg_wr_shift)
  );

  always_comb begin
    start_rank = (vtime_q > rd_finish) ? vtime_q : rd_finish;
    cost       = s_desc_len >> rd_shift;
    new_finish = sat_add(start_rank, cost);
    top_rank   = s_pifo_top[INFO_RANK_MSB:INFO_RANK_LSB];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      occ_q            <= '0;
      vtime_q          <= '0;
      m_pifo_insert_en <= 1'b0;
      m_pifo_info      <= '0;
      m_pifo_pop_en    <= 1'b0;
      deq_ack          <= 1'b0;
      deq_buf_addr     <= '0;
    end else begin
      m_pifo_insert_en <= accept;
      m_pifo_pop_en    <= pop_grant;
      deq_ack          <= m_pifo_pop_en;
      if (accept) begin
        m_pifo_info <= pack_info(start_rank, s_desc_buf_addr);
        occ_q       <= occ_q + CAL_CNT_WIDTH'(1);
      end else if (pop_grant) begin
        occ_q <= occ_q - CAL_CNT_WIDTH'(1);
      end
      // Virtual time only moves forward, even if an older low rank pops late.
      if (m_pifo_pop_en) begin
        deq_buf_addr <= s_pifo_top[INFO_ADDR_MSB:0];
        if (s_pifo_top[INFO_VALID_BIT] && (top_rank > vtime_q)) vtime_q <= top_rank;
      end
    end
  end

endmodule

// File: tb/tb_pifo_stfq_enqueue_ctrl.sv
// Directed bench for the STFQ enqueue controller with a behavioural rank-ordered
// calendar attached to the insert/pop strobes.
module tb_pifo_stfq_enqueue_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        s_desc_valid = 1'b0;
  logic        s_desc_ready;
  logic [11:0] s_desc_buf_addr = '0;
  logic [3:0]  s_desc_flow_id = '0;
  logic [15:0] s_desc_len = '0;
  logic        cfg_wr_valid = 1'b0;
  logic [3:0]  cfg_wr_flow = '0;
  logic [3:0]  cfg_wr_shift = '0;
  logic        deq_req = 1'b0;
  logic        deq_ack;
  logic [11:0] deq_buf_addr;
  logic        deq_empty;
  logic [31:0] m_pifo_info;
  logic        m_pifo_insert_en;
  logic        m_pifo_pop_en;
  logic [31:0] pifo_top = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pifo_stfq_enqueue_ctrl dut (
    .clk              (clk),
    .rstn             (rstn),
    .s_desc_valid     (s_desc_valid),
    .s_desc_ready     (s_desc_ready),
    .s_desc_buf_addr  (s_desc_buf_addr),
    .s_desc_flow_id   (s_desc_flow_id),
    .s_desc_len       (s_desc_len),
    .cfg_wr_valid     (cfg_wr_valid),
    .cfg_wr_flow      (cfg_wr_flow),
    .cfg_wr_shift     (cfg_wr_shift),
    .deq_req          (deq_req),
    .deq_ack          (deq_ack),
    .deq_buf_addr     (deq_buf_addr),
    .deq_empty        (deq_empty),
    .m_pifo_info      (m_pifo_info),
    .m_pifo_insert_en (m_pifo_insert_en),
    .m_pifo_pop_en    (m_pifo_pop_en),
    .s_pifo_top       (pifo_top)
  );

  // Calendar model: kept sorted by rank, equal ranks in arrival order.
  logic [31:0] cal_q[$];
  always @(posedge clk) begin
    int pos;
    if (!rstn) begin
      cal_q.delete();
    end else if (m_pifo_pop_en) begin
      if (cal_q.size() > 0) void'(cal_q.pop_front());
    end else if (m_pifo_insert_en) begin
      pos = cal_q.size();
      for (int i = 0; i < cal_q.size(); i++) begin
        if (cal_q[i][30:12] > m_pifo_info[30:12]) begin
          pos = i;
          break;
        end
      end
      cal_q.insert(pos, m_pifo_info);
    end
    pifo_top <= (cal_q.size() != 0) ? cal_q[0] : 32'h0;
  end

  // ---------------- driver tasks (caller is always at a negedge) ----------------
  task automatic idle_inputs();
    s_desc_valid = 1'b0;
    cfg_wr_valid = 1'b0;
    deq_req      = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Offers one descriptor for one cycle; returns in the cycle its insert is visible.
  task automatic push_desc(input logic [3:0] f, input logic [15:0] l, input logic [11:0] a);
    s_desc_valid    = 1'b1;
    s_desc_flow_id  = f;
    s_desc_len      = l;
    s_desc_buf_addr = a;
    @(negedge clk);
    s_desc_valid = 1'b0;
  endtask

  // One-cycle dequeue request; returns in the cycle deq_ack is expected.
  task automatic issue_pop();
    deq_req = 1'b1;
    @(negedge clk);
    deq_req = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    s_desc_valid = 1'b1;
    #1;
    total++; if (s_desc_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0h exp=0", s_desc_ready); end
    total++; if (m_pifo_insert_en !== 1'b0) begin bad++; $display("FAIL reset_insert got=%0h exp=0", m_pifo_insert_en); end
    total++; if (m_pifo_pop_en !== 1'b0) begin bad++; $display("FAIL reset_pop got=%0h exp=0", m_pifo_pop_en); end
    total++; if (deq_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%0h exp=0", deq_ack); end
    total++; if (deq_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0h exp=1", deq_empty); end
    total++; if (m_pifo_info !== 32'h0) begin bad++; $display("FAIL reset_info got=%h exp=0", m_pifo_info); end
    total++; if (deq_buf_addr !== 12'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", deq_buf_addr); end
    s_desc_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    total++; if (s_desc_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%0h exp=1", s_desc_ready); end
  endtask

  task automatic test_single_desc();
    do_reset();
    push_desc(4'd0, 16'd256, 12'h005);
    total++; if (m_pifo_insert_en !== 1'b1) begin bad++; $display("FAIL single_insert got=%0h exp=1", m_pifo_insert_en); end
    total++; if (m_pifo_info !== 32'h80000005) begin bad++; $display("FAIL single_info got=%h exp=80000005", m_pifo_info); end
    @(negedge clk);
    total++; if (m_pifo_insert_en !== 1'b0) begin bad++; $display("FAIL single_strobe_len got=%0h exp=0", m_pifo_insert_en); end
    total++; if (deq_empty !== 1'b0) begin bad++; $display("FAIL single_empty got=%0h exp=0", deq_empty); end
    push_desc(4'd0, 16'd0, 12'h006);
    total++; if (m_pifo_info !== 32'h80100006) begin bad++; $display("FAIL single_finish256 got=%h exp=80100006", m_pifo_info); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    s_desc_valid = 1'b1; s_desc_flow_id = 4'd5; s_desc_len = 16'd100; s_desc_buf_addr = 12'h010;
    @(negedge clk);
    s_desc_len = 16'd50; s_desc_buf_addr = 12'h011;
    total++; if (m_pifo_info !== 32'h80000010 || m_pifo_insert_en !== 1'b1) begin bad++; $display("FAIL b2b_first got=%h exp=80000010", m_pifo_info); end
    @(negedge clk);
    s_desc_valid = 1'b0;
    total++; if (m_pifo_info !== 32'h80064011 || m_pifo_insert_en !== 1'b1) begin bad++; $display("FAIL b2b_second got=%h exp=80064011", m_pifo_info); end
    @(negedge clk);
    push_desc(4'd5, 16'd0, 12'h012);
    total++; if (m_pifo_info !== 32'h80096012) begin bad++; $display("FAIL b2b_finish150 got=%h exp=80096012", m_pifo_info); end
  endtask

  task automatic test_cfg_same_cycle();
    do_reset();
    s_desc_valid = 1'b1; s_desc_flow_id = 4'd6; s_desc_len = 16'd100; s_desc_buf_addr = 12'h060;
    cfg_wr_valid = 1'b1; cfg_wr_flow = 4'd6; cfg_wr_shift = 4'd2;
    @(negedge clk);
    s_desc_valid = 1'b0; cfg_wr_valid = 1'b0;
    total++; if (m_pifo_info !== 32'h80000060) begin bad++; $display("FAIL cfg_first got=%h exp=80000060", m_pifo_info); end
    push_desc(4'd6, 16'd100, 12'h061);
    total++; if (m_pifo_info !== 32'h80064061) begin bad++; $display("FAIL cfg_old_shift got=%h exp=80064061", m_pifo_info); end
    push_desc(4'd6, 16'd0, 12'h062);
    total++; if (m_pifo_info !== 32'h8007d062) begin bad++; $display("FAIL cfg_new_shift got=%h exp=8007d062", m_pifo_info); end
  endtask

  task automatic test_pop_order();
    do_reset();
    cfg_wr_valid = 1'b1; cfg_wr_flow = 4'd2; cfg_wr_shift = 4'd1;
    @(negedge clk);
    cfg_wr_valid = 1'b0;
    push_desc(4'd1, 16'd100, 12'h020);
    total++; if (m_pifo_info !== 32'h80000020) begin bad++; $display("FAIL pop_ins0 got=%h exp=80000020", m_pifo_info); end
    push_desc(4'd2, 16'd40, 12'h030);
    total++; if (m_pifo_info !== 32'h80000030) begin bad++; $display("FAIL pop_ins1 got=%h exp=80000030", m_pifo_info); end
    push_desc(4'd1, 16'd100, 12'h021);
    total++; if (m_pifo_info !== 32'h80064021) begin bad++; $display("FAIL pop_ins2 got=%h exp=80064021", m_pifo_info); end
    push_desc(4'd2, 16'd40, 12'h031);
    total++; if (m_pifo_info !== 32'h80014031) begin bad++; $display("FAIL pop_ins3 got=%h exp=80014031", m_pifo_info); end
    @(negedge clk);
    deq_req = 1'b1;
    @(negedge clk);
    deq_req = 1'b0;
    total++; if (m_pifo_pop_en !== 1'b1 || deq_ack !== 1'b0) begin bad++; $display("FAIL pop_t1 got=%0h%0h exp=10", m_pifo_pop_en, deq_ack); end
    @(negedge clk);
    total++; if (deq_ack !== 1'b1 || deq_buf_addr !== 12'h020) begin bad++; $display("FAIL pop_first got=%0h/%h exp=1/020", deq_ack, deq_buf_addr); end
    @(negedge clk);
    total++; if (deq_ack !== 1'b0) begin bad++; $display("FAIL pop_ack_len got=%0h exp=0", deq_ack); end
    issue_pop();
    total++; if (deq_ack !== 1'b1 || deq_buf_addr !== 12'h030) begin bad++; $display("FAIL pop_second got=%0h/%h exp=1/030", deq_ack, deq_buf_addr); end
    issue_pop();
    total++; if (deq_ack !== 1'b1 || deq_buf_addr !== 12'h031) begin bad++; $display("FAIL pop_third got=%0h/%h exp=1/031", deq_ack, deq_buf_addr); end
    push_desc(4'd3, 16'd8, 12'h040);
    total++; if (m_pifo_info !== 32'h80014040) begin bad++; $display("FAIL pop_vtime20 got=%h exp=80014040", m_pifo_info); end
    @(negedge clk);
    deq_req = 1'b1;
    @(negedge clk);
    total++; if (m_pifo_pop_en !== 1'b1) begin bad++; $display("FAIL pop_consec_a got=%0h exp=1", m_pifo_pop_en); end
    @(negedge clk);
    deq_req = 1'b0;
    total++; if (m_pifo_pop_en !== 1'b1 || deq_ack !== 1'b1 || deq_buf_addr !== 12'h040) begin bad++; $display("FAIL pop_consec_b got=%0h%0h/%h exp=11/040", m_pifo_pop_en, deq_ack, deq_buf_addr); end
    @(negedge clk);
    total++; if (deq_ack !== 1'b1 || deq_buf_addr !== 12'h021 || m_pifo_pop_en !== 1'b0) begin bad++; $display("FAIL pop_consec_c got=%0h%0h/%h exp=10/021", deq_ack, m_pifo_pop_en, deq_buf_addr); end
    total++; if (deq_empty !== 1'b1) begin bad++; $display("FAIL pop_drained got=%0h exp=1", deq_empty); end
    @(negedge clk);
    total++; if (deq_ack !== 1'b0) begin bad++; $display("FAIL pop_consec_end got=%0h exp=0", deq_ack); end
  endtask

  task automatic test_vtime_monotonic();
    do_reset();
    push_desc(4'd0, 16'd500, 12'h0a0);
    push_desc(4'd0, 16'd0, 12'h0a1);
    @(negedge clk);
    issue_pop();
    deq_req = 1'b1;
    @(negedge clk);
    deq_req = 1'b0;
    s_desc_valid = 1'b1; s_desc_flow_id = 4'd1; s_desc_len = 16'd0; s_desc_buf_addr = 12'h0a2;
    @(negedge clk);
    s_desc_valid = 1'b0;
    total++; if (deq_ack !== 1'b1 || deq_buf_addr !== 12'h0a1) begin bad++; $display("FAIL mono_pop500 got=%0h/%h exp=1/0a1", deq_ack, deq_buf_addr); end
    total++; if (m_pifo_insert_en !== 1'b1 || m_pifo_info !== 32'h800000a2) begin bad++; $display("FAIL mono_late_ins got=%h exp=800000a2", m_pifo_info); end
    @(negedge clk);
    issue_pop();
    total++; if (deq_buf_addr !== 12'h0a2) begin bad++; $display("FAIL mono_pop0 got=%h exp=0a2", deq_buf_addr); end
    push_desc(4'd2, 16'd0, 12'h0a3);
    total++; if (m_pifo_info !== 32'h801f40a3) begin bad++; $display("FAIL mono_vtime got=%h exp=801f40a3", m_pifo_info); end
  endtask

  task automatic test_collision();
    do_reset();
    push_desc(4'd0, 16'd10, 12'h001);
    push_desc(4'd0, 16'd10, 12'h002);
    push_desc(4'd0, 16'd10, 12'h003);
    @(negedge clk);
    deq_req = 1'b1;
    s_desc_valid = 1'b1; s_desc_flow_id = 4'd7; s_desc_len = 16'd0; s_desc_buf_addr = 12'h070;
    #1;
    total++; if (s_desc_ready !== 1'b0) begin bad++; $display("FAIL coll_ready got=%0h exp=0", s_desc_ready); end
    @(negedge clk);
    deq_req = 1'b0;
    #1;
    total++; if (m_pifo_pop_en !== 1'b1 || m_pifo_insert_en !== 1'b0 || s_desc_ready !== 1'b1) begin bad++; $display("FAIL coll_t1 got=%0h%0h%0h exp=101", m_pifo_pop_en, m_pifo_insert_en, s_desc_ready); end
    @(negedge clk);
    s_desc_valid = 1'b0;
    total++; if (m_pifo_insert_en !== 1'b1 || m_pifo_pop_en !== 1'b0 || m_pifo_info !== 32'h80000070) begin bad++; $display("FAIL coll_ins got=%0h%0h/%h exp=10/80000070", m_pifo_insert_en, m_pifo_pop_en, m_pifo_info); end
    total++; if (deq_ack !== 1'b1 || deq_buf_addr !== 12'h001) begin bad++; $display("FAIL coll_ack got=%0h/%h exp=1/001", deq_ack, deq_buf_addr); end
  endtask

  task automatic test_fill();
    int acc;
    do_reset();
    acc = 0;
    s_desc_valid = 1'b1; s_desc_flow_id = 4'd8; s_desc_len = 16'd0;
    for (int i = 0; i < 1030; i++) begin
      s_desc_buf_addr = 12'(i);
      #1;
      if (s_desc_ready === 1'b1) acc++;
      @(negedge clk);
    end
    @(negedge clk);
    total++; if (acc !== 1024) begin bad++; $display("FAIL fill_accepted got=%0d exp=1024", acc); end
    total++; if (s_desc_ready !== 1'b0 || m_pifo_insert_en !== 1'b0) begin bad++; $display("FAIL fill_full got=%0h%0h exp=00", s_desc_ready, m_pifo_insert_en); end
    total++; if (cal_q.size() !== 1024) begin bad++; $display("FAIL fill_cal_size got=%0d exp=1024", cal_q.size()); end
    deq_req = 1'b1;
    @(negedge clk);
    deq_req = 1'b0;
    #1;
    total++; if (s_desc_ready !== 1'b1) begin bad++; $display("FAIL fill_reopen got=%0h exp=1", s_desc_ready); end
    @(negedge clk);
    s_desc_valid = 1'b0;
    #1;
    total++; if (deq_ack !== 1'b1 || deq_buf_addr !== 12'h000 || m_pifo_insert_en !== 1'b1) begin bad++; $display("FAIL fill_refill got=%0h%0h/%h exp=11/000", deq_ack, m_pifo_insert_en, deq_buf_addr); end
    total++; if (s_desc_ready !== 1'b0) begin bad++; $display("FAIL fill_refull got=%0h exp=0", s_desc_ready); end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 8; k++) push_desc(4'd3, 16'hffff, 12'(k));
    total++; if (m_pifo_info !== 32'hefff9007) begin bad++; $display("FAIL sat_eighth got=%h exp=efff9007", m_pifo_info); end
    push_desc(4'd3, 16'hffff, 12'h009);
    total++; if (m_pifo_info !== 32'hffff8009) begin bad++; $display("FAIL sat_ninth got=%h exp=ffff8009", m_pifo_info); end
    push_desc(4'd3, 16'h0000, 12'h00a);
    total++; if (m_pifo_info !== 32'hfffff00a) begin bad++; $display("FAIL sat_clamped got=%h exp=fffff00a", m_pifo_info); end
    push_desc(4'd3, 16'hffff, 12'h00b);
    total++; if (m_pifo_info !== 32'hfffff00b) begin bad++; $display("FAIL sat_hold got=%h exp=fffff00b", m_pifo_info); end
  endtask

  task automatic test_empty_deq();
    do_reset();
    deq_req = 1'b1;
    #1;
    total++; if (s_desc_ready !== 1'b1 || deq_empty !== 1'b1) begin bad++; $display("FAIL empty_req got=%0h%0h exp=11", s_desc_ready, deq_empty); end
    @(negedge clk);
    deq_req = 1'b0;
    total++; if (m_pifo_pop_en !== 1'b0) begin bad++; $display("FAIL empty_pop got=%0h exp=0", m_pifo_pop_en); end
    @(negedge clk);
    total++; if (deq_ack !== 1'b0 || deq_empty !== 1'b1) begin bad++; $display("FAIL empty_ack got=%0h%0h exp=01", deq_ack, deq_empty); end
  endtask

  task automatic test_reset_mid_pop();
    do_reset();
    push_desc(4'd0, 16'd0, 12'h077);
    @(negedge clk);
    deq_req = 1'b1;
    @(negedge clk);
    deq_req = 1'b0;
    total++; if (m_pifo_pop_en !== 1'b1) begin bad++; $display("FAIL rmid_pop got=%0h exp=1", m_pifo_pop_en); end
    rstn = 1'b0;
    @(negedge clk);
    total++; if (deq_ack !== 1'b0 || m_pifo_pop_en !== 1'b0 || s_desc_ready !== 1'b0 || deq_empty !== 1'b1) begin bad++; $display("FAIL rmid_in_reset got=%0h%0h%0h%0h exp=0001", deq_ack, m_pifo_pop_en, s_desc_ready, deq_empty); end
    rstn = 1'b1;
    @(negedge clk);
    total++; if (deq_ack !== 1'b0 || deq_empty !== 1'b1 || s_desc_ready !== 1'b1) begin bad++; $display("FAIL rmid_after got=%0h%0h%0h exp=011", deq_ack, deq_empty, s_desc_ready); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_desc();
    test_back_to_back();
    test_cfg_same_cycle();
    test_pop_order();
    test_vtime_monotonic();
    test_collision();
    test_fill();
    test_saturation();
    test_empty_deq();
    test_reset_mid_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end

endmodule
